// File: rtl/axis_pack_pkg.sv
// axis_pack_pkg: shared constants and helpers for the axis_pack slice.
//   calc_ratio  : lanes per output word (OUT_W / IN_W)
//   calc_lane_w : width of lane counters, wide enough to hold RATIO itself
//   lane_offset : bit offset of a lane inside the packed word (little-endian)
package axis_pack_pkg;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_OUT_W = 32;
  localparam int DEF_CNT_W = 32;

  function automatic int calc_ratio(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction

  function automatic int calc_lane_w(input int ratio);
    return $clog2(ratio) + 1;
  endfunction

  function automatic int lane_offset(input int lane, input int in_w);
    return lane * in_w;
  endfunction

endpackage

// File: rtl/axis_pack_if.sv
// axis_pack stream interfaces.
//   axis_pack_in_if  : narrow input stream  (data, valid, ready[, last])
//   axis_pack_out_if : packed output stream (data, valid, ready[, last, nlanes])
// last/nlanes exist only when IOB_AXIS_PACK_LAST_EN is defined.
interface axis_pack_in_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
`ifdef IOB_AXIS_PACK_LAST_EN
  logic              last;
  modport master (output data, valid, last, input ready);
  modport slave  (input data, valid, last, output ready);
`else
  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
`endif
endinterface

interface axis_pack_out_if #(
  parameter int DATA_W = 32
`ifdef IOB_AXIS_PACK_LAST_EN
  , parameter int LANE_W = 3
`endif
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
`ifdef IOB_AXIS_PACK_LAST_EN
  logic              last;
  logic [LANE_W-1:0] nlanes;
  modport master (output data, valid, last, nlanes, input ready);
  modport slave  (input data, valid, last, nlanes, output ready);
`else
  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
`endif
endinterface

// File: rtl/axis_pack_oreg.sv
// axis_pack_oreg: output register of the packer.
// Holds data (and last/nlanes with IOB_AXIS_PACK_LAST_EN) stable while
// valid & ~ready; load_i may coincide with a downstream accept, in which case
// the new word replaces the old one with valid kept high.
// Ports: clk_i, cke_i, rst_i, clear_i, load_i, load_data_i[, load_last_i,
//        load_nlanes_i], ready_i, valid_o, data_o[, last_o, nlanes_o]
module axis_pack_oreg #(
  parameter int DATA_W = 32
`ifdef IOB_AXIS_PACK_LAST_EN
  , parameter int LANE_W = 3
`endif
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
`ifdef IOB_AXIS_PACK_LAST_EN
  input  logic              load_last_i,
  input  logic [LANE_W-1:0] load_nlanes_i,
  output logic              last_o,
  output logic [LANE_W-1:0] nlanes_o,
`endif
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
`ifdef IOB_AXIS_PACK_LAST_EN
  logic              last_p1;
  logic [LANE_W-1:0] nlanes_p1;
`endif

  // ---- stage p1: output register ----
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i || clear_i) begin
        vld_p1    <= 1'b0;
        data_p1   <= '0;
`ifdef IOB_AXIS_PACK_LAST_EN
        last_p1   <= 1'b0;
        nlanes_p1 <= '0;
`endif
      end else if (load_i) begin
        vld_p1    <= 1'b1;
        data_p1   <= load_data_i;
`ifdef IOB_AXIS_PACK_LAST_EN
        last_p1   <= load_last_i;
        nlanes_p1 <= load_nlanes_i;
`endif
      end else if (vld_p1 && ready_i) begin
        vld_p1    <= 1'b0;
      end
    end
  end

  assign valid_o  = vld_p1;
  assign data_o   = data_p1;
`ifdef IOB_AXIS_PACK_LAST_EN
  assign last_o   = last_p1;
  assign nlanes_o = nlanes_p1;
`endif

endmodule

// File: rtl/axis_pack.sv
// axis_pack: packs a narrow AXI stream into OUT_W-bit words, lane 0 in the
// least significant bits, and counts words accepted downstream.
// Optional feature macro: IOB_AXIS_PACK_LAST_EN -- adds input/output tlast and
// nlanes; tlast flushes a partial word (unfilled lanes are zero).
// Ports: clk_i, cke_i (state holds while low), rst_i (sync, active-high),
//        clear_i (soft clear), axis_in (narrow stream, slave),
//        axis_out (packed stream, master), word_cnt_o (wrapping word count).
module axis_pack
  import axis_pack_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk_i,
  input  logic                   cke_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  axis_pack_in_if.slave          axis_in,
  axis_pack_out_if.master        axis_out,
  output logic [CNT_W-1:0]       word_cnt_o
);

  localparam int RATIO  = calc_ratio(IN_W, OUT_W);
  localparam int LANE_W = calc_lane_w(RATIO);

  logic [LANE_W-1:0] lane_cnt_p0;
  logic [OUT_W-1:0]  acc_p0;
  logic [OUT_W-1:0]  word_nxt;
  logic [CNT_W-1:0]  word_cnt;
  logic              in_ready;
  logic              in_last;
  logic              accept;
  logic              complete;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;

  // Ready only looks at the output register: a free or draining output slot
  // means a completing beat always has somewhere to go.
  assign in_ready      = ~rst_i & (~out_valid | axis_out.ready);
  assign axis_in.ready = in_ready;
  assign accept        = cke_i & axis_in.valid & in_ready;

`ifdef IOB_AXIS_PACK_LAST_EN
  assign in_last = axis_in.last;
`else
  assign in_last = 1'b0;
`endif

  assign complete = accept & ((lane_cnt_p0 == LANE_W'(RATIO - 1)) | in_last);

  // Accumulator merged with the current beat at its lane.
  always_comb begin
    word_nxt = acc_p0;
    for (int l = 0; l < RATIO; l++) begin
      if (lane_cnt_p0 == LANE_W'(l))
        word_nxt[lane_offset(l, IN_W) +: IN_W] = axis_in.data;
    end
  end

  // ---- stage p0: packing accumulator ----
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i || clear_i || complete) begin
        lane_cnt_p0 <= '0;
        acc_p0      <= '0;
      end else if (accept) begin
        lane_cnt_p0 <= lane_cnt_p0 + LANE_W'(1);
        acc_p0      <= word_nxt;
      end
    end
  end

  axis_pack_oreg #(
    .DATA_W        (OUT_W)
`ifdef IOB_AXIS_PACK_LAST_EN
    , .LANE_W      (LANE_W)
`endif
  ) u_oreg (
    .clk_i         (clk_i),
    .cke_i         (cke_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .load_i        (complete),
    .load_data_i   (word_nxt),
`ifdef IOB_AXIS_PACK_LAST_EN
    .load_last_i   (in_last),
    .load_nlanes_i (lane_cnt_p0 + LANE_W'(1)),
    .last_o        (axis_out.last),
    .nlanes_o      (axis_out.nlanes),
`endif
    .ready_i       (axis_out.ready),
    .valid_o       (out_valid),
    .data_o        (out_data)
  );

  assign axis_out.valid = out_valid;
  assign axis_out.data  = out_data;

  // ---- stage p1: downstream word counter ----
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i || clear_i)
        word_cnt <= '0;
      else if (out_valid && axis_out.ready)
        word_cnt <= word_cnt + CNT_W'(1);
    end
  end

  assign word_cnt_o = word_cnt;

endmodule

// File: tb/tb_axis_pack.sv
// tb_axis_pack: scoreboard bench for axis_pack (IN_W=8, OUT_W=32, CNT_W=4).
// A byte-queue model builds expected words as beats are accepted; a monitor
// on the falling edge pops and compares whenever a word is presented.
module tb_axis_pack;
  import axis_pack_pkg::*;

  localparam int IN_W   = 8;
  localparam int OUT_W  = 32;
  localparam int CNT_W  = 4;
  localparam int RATIO  = calc_ratio(IN_W, OUT_W);
  localparam int LANE_W = calc_lane_w(RATIO);
`ifdef IOB_AXIS_PACK_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  typedef struct {
    logic [OUT_W-1:0]  data;
    logic              last;
    logic [LANE_W-1:0] nlanes;
    int                cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             cke, rst, clear;
  logic [CNT_W-1:0] word_cnt;
  logic             rdy_dir, rnd_rdy, rnd_en;

  exp_t             exp_q[$];
  logic [IN_W-1:0]  part_q[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               hs_cnt = 0;
  bit               new_word = 1'b1;

  axis_pack_in_if #(.DATA_W(IN_W)) in_if ();
`ifdef IOB_AXIS_PACK_LAST_EN
  axis_pack_out_if #(.DATA_W(OUT_W), .LANE_W(LANE_W)) out_if ();
`else
  axis_pack_out_if #(.DATA_W(OUT_W)) out_if ();
`endif

  assign out_if.ready = rnd_en ? rnd_rdy : rdy_dir;

  axis_pack #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk_i      (clk),
    .cke_i      (cke),
    .rst_i      (rst),
    .clear_i    (clear),
    .axis_in    (in_if),
    .axis_out   (out_if),
    .word_cnt_o (word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rnd_en) begin #1 rnd_rdy = 1'($urandom_range(0, 1)); end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: collect accepted bytes; a word is due after RATIO bytes or on tlast.
  function automatic void model_accept(input logic [IN_W-1:0] d, input bit lst);
    exp_t e;
    part_q.push_back(d);
    if (part_q.size() == RATIO || (LAST_EN && lst)) begin
      e.data = '0;
      for (int i = 0; i < part_q.size(); i++)
        e.data = e.data | (OUT_W'(part_q[i]) << (i * IN_W));
      e.nlanes = LANE_W'(part_q.size());
      e.last   = lst;
      e.cyc    = cyc;
      exp_q.push_back(e);
      part_q.delete();
    end
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (cke && (rst || clear)) begin
      exp_q.delete();
      part_q.delete();
      hs_cnt   = 0;
      new_word = 1'b1;
    end else begin
      check("word_cnt", 64'(word_cnt), 64'(hs_cnt % (1 << CNT_W)));
      if (out_if.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got valid data %0h expected no word", out_if.data);
        end else begin
          check("out_data", 64'(out_if.data), 64'(exp_q[0].data));
`ifdef IOB_AXIS_PACK_LAST_EN
          check("out_last", 64'(out_if.last), 64'(exp_q[0].last));
          check("out_nlanes", 64'(out_if.nlanes), 64'(exp_q[0].nlanes));
`endif
          if (new_word) check("latency", 64'(cyc), 64'(exp_q[0].cyc + 1));
          if (cke && out_if.ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
            new_word = 1'b1;
          end else begin
            new_word = 1'b0;
          end
        end
      end else begin
        new_word = 1'b1;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [IN_W-1:0] d, input bit lst, input int gap);
    bit ok = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    in_if.valid = 1'b1;
    in_if.data  = d;
`ifdef IOB_AXIS_PACK_LAST_EN
    in_if.last  = lst;
`endif
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (cke && in_if.ready === 1'b1) begin
        model_accept(d, lst);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_if.valid = 1'b0;
    check("beat_accepted", 64'(ok), 64'(1));
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    rdy_dir = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && out_if.valid !== 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    check("drain", 64'(ok), 64'(1));
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    cke = 1'b1; rst = 1'b1; clear = 1'b0;
    rdy_dir = 1'b1; rnd_rdy = 1'b1; rnd_en = 1'b0;
    in_if.valid = 1'b0; in_if.data = '0;
`ifdef IOB_AXIS_PACK_LAST_EN
    in_if.last = 1'b0;
`endif
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(out_if.valid), 64'(0));
    check("rst_data", 64'(out_if.data), 64'(0));
    check("rst_cnt", 64'(word_cnt), 64'(0));
    check("rst_in_ready", 64'(in_if.ready), 64'(0));
`ifdef IOB_AXIS_PACK_LAST_EN
    check("rst_last", 64'(out_if.last), 64'(0));
    check("rst_nlanes", 64'(out_if.nlanes), 64'(0));
`endif
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_if.ready), 64'(1));
    @(posedge clk); #1;

    // Streaming: 8 bytes back to back, one per cycle
    t0 = cyc;
    for (int i = 1; i <= 8; i++) send_beat(IN_W'(i * 8'h11), 1'b0, 0);
    check("stream_cycles", 64'(cyc - t0), 64'(8));
    wait_drain();
    check("stream_cnt", 64'(word_cnt), 64'(2));

    // Backpressure: first word held while downstream stalls
    rdy_dir = 1'b0;
    for (int i = 1; i <= 4; i++) send_beat(IN_W'(i * 8'h11), 1'b0, 0);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_if.ready), 64'(0));
      check("bp_hold_data", 64'(out_if.data), 64'(32'h44332211));
      @(posedge clk); #1;
    end
    fork
      for (int i = 5; i <= 8; i++) send_beat(IN_W'(i * 8'h11), 1'b0, 0);
      begin repeat (5) @(posedge clk); #1 rdy_dir = 1'b1; end
    join
    wait_drain();
    check("bp_cnt", 64'(word_cnt), 64'(4));

    // Partial flush via tlast, then a full word ending in tlast
    send_beat(8'hAA, 1'b0, 0);
    send_beat(8'hBB, 1'b1, 0);
    for (int i = 1; i <= 4; i++) send_beat(IN_W'(i), i == 4, 0);
    wait_drain();
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("no_partial_out", 64'(out_if.valid), 64'(0));
    @(posedge clk); #1;

    // Clear mid-word
    pulse_clear();
    for (int i = 0; i < 3; i++) send_beat(8'hA1 + IN_W'(i), 1'b0, 0);
    pulse_clear();
    for (int i = 1; i <= 4; i++) send_beat(IN_W'(i), 1'b0, 0);
    wait_drain();
    check("clear_cnt", 64'(word_cnt), 64'(1));

    // Clock enable low: beats, clear and readiness ignored
    send_beat(8'h10, 1'b0, 0);
    send_beat(8'h20, 1'b0, 0);
    cke = 1'b0; clear = 1'b1; in_if.valid = 1'b1; in_if.data = 8'hEE;
    repeat (4) @(posedge clk);
    #1 cke = 1'b1; clear = 1'b0; in_if.valid = 1'b0;
    send_beat(8'h30, 1'b0, 0);
    send_beat(8'h40, 1'b0, 0);
    wait_drain();
    check("cke_cnt", 64'(word_cnt), 64'(2));

    // Counter wrap: 17 words modulo 16
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 17 * RATIO; i++) send_beat(IN_W'(i * 3 + 1), 1'b0, 0);
    wait_drain();
    check("wrap_cnt", 64'(word_cnt), 64'(1));

    // Random traffic with random downstream stalls
    rnd_en = 1'b1;
    for (int i = 0; i < 300; i++)
      send_beat(IN_W'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 2));
    @(posedge clk); #1 rnd_en = 1'b0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
